reset_sequencer: RTL

Parametrised reset controller for the Next186 platform tops. It merges NSRC asynchronous reset requests, for example the OSD status reset bit and the board button, into one clean reset event. Each request is synchronised and gated by a mask, the reset is held for a guaranteed minimum width, and NOUT staged reset outputs are released in order (SDRAM controller, then peripherals, then CPU). It also records which sources caused the last reset. It replaces the single-flop `reset <= status | button` logic in the platform top.

---
 rtl/reset_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Merges masked asynchronous reset requests into one stretched reset, then releases NOUT staged outputs in order.
// Latency: request to all outputs high is SYNC_STAGES+1 edges; no backpressure, every input is a level.
module reset_sequencer #(
  parameter int NSRC        = 2,
  parameter int NOUT        = 3,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 16,
  parameter int STAGE_DELAY = 256
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic [NSRC-1:0] req,
  input  logic [NSRC-1:0] req_mask,
  input  logic            cause_clr,
  output logic [NOUT-1:0] rst_out,
  output logic            busy,
  output logic [NSRC-1:0] cause
);

  localparam int CMAX = (MIN_PULSE > STAGE_DELAY) ? MIN_PULSE : STAGE_DELAY;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(NOUT + 1);

  localparam logic [CW-1:0] PULSE_END = CW'(MIN_PULSE - 1);
  localparam logic [CW-1:0] STAGE_END = CW'(STAGE_DELAY - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NOUT - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NOUT-1:0] rst_d;
  logic            busy_d;

  logic [NSRC-1:0] sync_q [SYNC_STAGES];
  logic [NSRC-1:0] req_s;
  logic [NSRC-1:0] hit;
  logic            act;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= req;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];
  assign hit   = req_s & req_mask;
  assign act   = |hit;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_out <= '1;
      busy    <= 1'b1;
      cause   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_out <= rst_d;
      busy    <= busy_d;
      // A clear coinciding with a fresh hit keeps that bit set.
      cause   <= (cause & ~{NSRC{cause_clr}}) | hit;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_out;

    case (state_q)
      ST_ASSERT: begin
        rst_d = '1;
        if (act) begin
          cnt_d = '0;
        end else if (cnt_q != PULSE_END) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          rst_d[0] = 1'b0;
          cnt_d    = '0;
          if (NOUT == 1) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_RELEASE;
            idx_d   = IW'(1);
          end
        end
      end

      ST_RELEASE: begin
        // A new request wins over a stage release due on the same edge.
        if (act) begin
          state_d = ST_ASSERT;
          rst_d   = '1;
          cnt_d   = '0;
        end else if (cnt_q == STAGE_END) begin
          for (int k = 0; k < NOUT; k++) begin
            if (idx_q == IW'(k)) rst_d[k] = 1'b0;
          end
          cnt_d = '0;
          idx_d = idx_q + IW'(1);
          if (idx_q == LAST_IDX) state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_RUN: begin
        rst_d = '0;
        if (act) begin
          state_d = ST_ASSERT;
          rst_d   = '1;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_ASSERT;
        rst_d   = '1;
        cnt_d   = '0;
      end
    endcase

    busy_d = |rst_d;
  end

endmodule
